// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a combinational instruction memory from a
// pc register and queues {pc, instr} pairs in a 2-entry FIFO toward decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        fault,
  output logic [1:0]  state
);

  // Decode side handshake: a transfer happens on a rising edge where if_valid and
  // if_ready are both high; the head stays stable while if_valid && !if_ready.

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [31:0] LAST_PC = 32'(4 * MEM_WORDS - 4);

  state_e      state_q, state_d;
  logic        fault_q, fault_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  entry_t      e0_q, e0_d, e1_q, e1_d;

  logic   pop;
  logic   push;
  logic   flush;
  entry_t new_entry;

  assign imem_addr = pc_q;
  assign if_valid  = (count_q != 2'd0);
  assign if_pc     = e0_q.pc;
  assign if_instr  = e0_q.instr;
  assign fault     = fault_q;
  assign state     = state_q;
  assign pop       = if_valid && if_ready;
  assign new_entry = '{pc: pc_q, instr: imem_instr};

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (state_q != ST_FAULT && redirect_valid) begin
      // Any redirect empties the queue; a misaligned target faults without moving pc.
      flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else begin
        pc_d    = redirect_pc;
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RUN) begin
      if (pc_q > LAST_PC) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else if (halt_req) begin
        state_d = ST_HALT;
      end else if (count_q != 2'd2 || pop) begin
        push = 1'b1;
        pc_d = pc_q + 32'd4;
      end
    end else if (state_q == ST_HALT) begin
      if (!halt_req) state_d = ST_RUN;
    end
  end

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) e0_d = new_entry;
          else                 e1_d = new_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever remains.
          if (count_q == 2'd1) begin
            e0_d = new_entry;
          end else begin
            e0_d = e1_q;
            e1_d = new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fault_q <= 1'b0;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

endmodule
